dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single byte-addressed data memory between two requesters: port 0 (CPU load/store unit) and port 1 (DMA/debug loader).
- Round-robin arbitration between the two ports.
- Converts RISC-V funct3 sizes into byte write enables.
- Sign- or zero-extends load data.
- Sits between the requesters and the data memory; drives its WE0..WE3/A/WD and samples its combinational RD.

Parameters:
ADDRESS_WIDTH, 17, byte address width; must match the data memory.
DATA_WIDTH, 32, data word width; fixed at 32 by the funct3 decode.

Ports:
CLK  input  1  clock; all state changes on posedge
RST_N  input  1  asynchronous, active-low reset
p0_req  input  1  port 0 request; held with payload until p0_gnt
p0_we  input  1  port 0: 1 = store, 0 = load
p0_funct3  input  3  port 0 size/sign (RISC-V load/store funct3)
p0_addr  input  ADDRESS_WIDTH  port 0 byte address
p0_wdata  input  DATA_WIDTH  port 0 store data, LSB-aligned
p0_gnt  output  1  port 0 request accepted this cycle (combinational)
p0_done  output  1  one-cycle pulse: port 0 access complete
p0_rdata  output  DATA_WIDTH  port 0 extended load data
p0_err  output  1  port 0 access faulted; valid with p0_done
p1_*  same set as p0_*, for port 1
mem_we0..mem_we3  output  1 each  byte write enables to memory
mem_a  output  ADDRESS_WIDTH  memory address
mem_wd  output  DATA_WIDTH  memory write data
mem_rd  input  DATA_WIDTH  memory combinational read data

Behaviour:
- FSM states:
  - IDLE -> ACCESS on any req.
  - ACCESS -> DONE unconditionally.
  - DONE -> IDLE unconditionally.
  - Fixed 3-cycle occupancy per access; no pipelining.
- Grant:
  - Only in IDLE.
  - pX_gnt = pX_req & winner; at most one gnt high.
  - On gnt: latch owner, we, funct3, addr, wdata into internal registers. The requester may change or drop its payload after gnt.
- Arbitration:
  - Single requester wins.
  - Both requesting: grant the port not served last; the last-served pointer updates on every gnt.
  - Reset pointer = port 1 last served, so port 0 wins the first tie.
  - req dropped before gnt: ignored, no side effects.
- ACCESS:
  - mem_a = latched addr (unmodified; wrap at 2^ADDRESS_WIDTH is the memory's behaviour); mem_wd = latched wdata.
  - Store write enables, asserted for this cycle only:
    - funct3[1:0]=00: we0.
    - 01: we0..we1.
    - 10 and 11: we0..we3.
    - funct3[2] ignored for stores.
  - Load: no WE; at the end of ACCESS, register the extended mem_rd into the owner's rdata.
- Load extension:
  - 000 LB: sign-extend rd[7:0].
  - 001 LH: sign-extend rd[15:0].
  - 010 LW: rd.
  - 100 LBU: zero-extend [7:0].
  - 101 LHU: zero-extend [15:0].
  - 011/110/111: treated as LW.
- DONE:
  - Owner's pX_done = 1 for exactly one cycle; the other port's done = 0.
  - pX_rdata holds its value until that port's next load completes; stores leave rdata unchanged.
- Outputs outside ACCESS: mem_we* = 0. mem_a and mem_wd show the latched values (don't-care).
- Reset (RST_N low, any state):
  - FSM -> IDLE immediately; gnt/done/err/mem_we* = 0 asynchronously.
  - rdata, latched registers and mem_a/mem_wd = 0.
  - A store in ACCESS when reset asserts is abandoned (WE drops before the clock edge).
  - No done for the aborted access.
- Back-to-back: the earliest re-grant is the IDLE cycle after DONE, so throughput is one access per 3 cycles.

Optional Feature:
DMEM_ARB_MISALIGN_CHK_EN
- Defined:
  - Misaligned accesses are rejected: halfword (funct3[1:0]=01) with addr[0]=1; word (10/11) with addr[1:0]!=0; funct3 011/110/111 on a load.
  - Rejected access: ACCESS cycle issues no WE; rdata is set to 0; pX_err = 1 with pX_done.
  - Timing unchanged.
- Undefined:
  - No check; misaligned accesses are performed as-is (the memory supports unaligned byte lanes).
  - pX_err tied to 0.

Test Plan:
- Reset/idle: RST_N low mid-ACCESS of p0 SW 0x10000 = 0xDEADBEEF -> mem_we* drop immediately; no p0_done; memory at 0x10000 unchanged; all outputs 0.
- Store/load sizes: p0 SW 0x10000 = 0x8899AABB, then LB -> 0xFFFFFFBB, LBU -> 0x000000BB, LH -> 0xFFFFAABB, LHU -> 0x0000AABB, LW -> 0x8899AABB; each done 2 cycles after gnt.
- Partial store: SB 0x10001 = 0x12345677 after the word above -> only we0 in ACCESS; a following LW 0x10000 -> 0x889977BB.
- Arbitration: p0 and p1 req held continuously from reset -> grants alternate p0, p1, p0, p1 every 3 cycles; never both gnt; done pulses match the owner.
- Misalign (macro defined): p1 LW 0x10002 -> p1_done with p1_err = 1, p1_rdata = 0, no WE. Macro undefined: same access -> err = 0, data = bytes 0x10002..0x10005.
- Drop before grant: p1_req pulses while p0 owns (ACCESS) and is gone by IDLE -> no p1_gnt, no memory access for p1.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one byte-addressed data memory between two requesters:
//   port 0 - CPU load/store unit
//   port 1 - DMA / debug loader
//
// Every access occupies the arbiter for three cycles (IDLE -> ACCESS -> DONE).
// A grant is only possible in IDLE. When both ports request at once, the port
// that was not served last wins; after reset port 1 counts as last served, so
// port 0 wins the first tie. The granted payload is captured at grant time, so
// the requester may change or drop it afterwards.
//
// In ACCESS the captured address and write data drive the memory. Stores
// raise byte enables decoded from funct3[1:0]. Loads capture the extended
// mem_rd into the owner's rdata register at the end of ACCESS. In DONE the
// owner's done pulses for one cycle.
//
// Optional feature (compile-time macro): DMEM_ARB_MISALIGN_CHK_EN
//   defined   : misaligned halfword/word accesses and load funct3 011/110/111
//               are rejected - no write enables, owner rdata cleared,
//               err raised together with done.
//   undefined : no check, accesses go to memory as-is, err stays 0.
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   pX_req/we/funct3    request, store(1)/load(0), RISC-V size/sign code
//   pX_addr/pX_wdata    byte address, LSB-aligned store data
//   pX_gnt              combinational grant (IDLE only)
//   pX_done/pX_err      one-cycle completion pulse, fault flag valid with done
//   pX_rdata            extended load data, held until that port's next load
//   mem_we0..mem_we3    byte-lane write enables (ACCESS of a store only)
//   mem_a/mem_wd        captured address / write data
//   mem_rd              combinational read data from memory
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDRESS_WIDTH = 17,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     p0_req,
    input  logic                     p0_we,
    input  logic [2:0]               p0_funct3,
    input  logic [ADDRESS_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0]    p0_wdata,
    output logic                     p0_gnt,
    output logic                     p0_done,
    output logic [DATA_WIDTH-1:0]    p0_rdata,
    output logic                     p0_err,
    input  logic                     p1_req,
    input  logic                     p1_we,
    input  logic [2:0]               p1_funct3,
    input  logic [ADDRESS_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0]    p1_wdata,
    output logic                     p1_gnt,
    output logic                     p1_done,
    output logic [DATA_WIDTH-1:0]    p1_rdata,
    output logic                     p1_err,
    output logic                     mem_we0,
    output logic                     mem_we1,
    output logic                     mem_we2,
    output logic                     mem_we3,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Byte-lane enables for a store; funct3[2] carries no meaning for stores.
    function automatic logic [3:0] store_be(input logic [2:0] funct3);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001;
            2'b01:   be = 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Sign/zero extension of the raw memory word; unused codes behave as LW.
    function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [2:0]            funct3,
                                                        input logic [DATA_WIDTH-1:0] rd);
        logic [DATA_WIDTH-1:0] v;
        case (funct3)
            3'b000:  v = {{(DATA_WIDTH-8){rd[7]}}, rd[7:0]};
            3'b001:  v = {{(DATA_WIDTH-16){rd[15]}}, rd[15:0]};
            3'b100:  v = {{(DATA_WIDTH-8){1'b0}}, rd[7:0]};
            3'b101:  v = {{(DATA_WIDTH-16){1'b0}}, rd[15:0]};
            default: v = rd;
        endcase
        return v;
    endfunction

`ifdef DMEM_ARB_MISALIGN_CHK_EN
    // Alignment fault: size from funct3[1:0], plus the reserved load codes.
    function automatic logic misaligned(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        logic bad;
        case (funct3[1:0])
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr_lo[0];
            default: bad = (addr_lo != 2'b00);
        endcase
        bad = bad | (!we && ((funct3 == 3'b011) || (funct3[2:1] == 2'b11)));
        return bad;
    endfunction
`endif

    state_e                   state_q, state_d;
    logic                     owner_q, owner_d;   // 0 = port 0, 1 = port 1
    logic                     last_q, last_d;     // last served port
    logic                     we_q, we_d;
    logic [2:0]               funct3_q, funct3_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0]    rdata1_q, rdata1_d;
    logic                     err_q, err_d;
    logic                     win_s;
    logic                     misalign_s;
    logic [3:0]               mem_we_s;
    logic [DATA_WIDTH-1:0]    ld_val_s;

`ifdef DMEM_ARB_MISALIGN_CHK_EN
    assign misalign_s = misaligned(we_q, funct3_q, addr_q[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    // Next-state, grant, capture and write-enable decode.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        err_d    = err_q;
        win_s    = 1'b0;
        p0_gnt   = 1'b0;
        p1_gnt   = 1'b0;
        mem_we_s = 4'b0000;
        ld_val_s = {DATA_WIDTH{1'b0}};

        case (state_q)
            ST_IDLE: begin
                // Tie goes to the port not served last; a lone requester wins.
                if (p0_req && p1_req) begin
                    win_s = ~last_q;
                end else begin
                    win_s = p1_req;
                end
                // RST_N gating keeps grants low while reset is held.
                if (RST_N && (p0_req || p1_req)) begin
                    p0_gnt   = ~win_s;
                    p1_gnt   = win_s;
                    owner_d  = win_s;
                    last_d   = win_s;
                    we_d     = win_s ? p1_we     : p0_we;
                    funct3_d = win_s ? p1_funct3 : p0_funct3;
                    addr_d   = win_s ? p1_addr   : p0_addr;
                    wdata_d  = win_s ? p1_wdata  : p0_wdata;
                    state_d  = ST_ACCESS;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d = ST_DONE;
                err_d   = misalign_s;
                if (we_q && !misalign_s) begin
                    mem_we_s = store_be(funct3_q);
                end else begin
                    mem_we_s = 4'b0000;
                end
                // Loads capture extended data; a rejected access clears rdata.
                if (!we_q || misalign_s) begin
                    ld_val_s = misalign_s ? {DATA_WIDTH{1'b0}} : load_ext(funct3_q, mem_rd);
                    if (owner_q) begin
                        rdata1_d = ld_val_s;
                    end else begin
                        rdata0_d = ld_val_s;
                    end
                end else begin
                    ld_val_s = {DATA_WIDTH{1'b0}};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= {ADDRESS_WIDTH{1'b0}};
            wdata_q  <= {DATA_WIDTH{1'b0}};
            rdata0_q <= {DATA_WIDTH{1'b0}};
            rdata1_q <= {DATA_WIDTH{1'b0}};
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            err_q    <= err_d;
        end
    end

    assign p0_done  = (state_q == ST_DONE) && !owner_q;
    assign p1_done  = (state_q == ST_DONE) &&  owner_q;
    assign p0_err   = p0_done && err_q;
    assign p1_err   = p1_done && err_q;
    assign p0_rdata = rdata0_q;
    assign p1_rdata = rdata1_q;
    assign mem_we0  = mem_we_s[0];
    assign mem_we1  = mem_we_s[1];
    assign mem_we2  = mem_we_s[2];
    assign mem_we3  = mem_we_s[3];
    assign mem_a    = addr_q;
    assign mem_wd   = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Drives directed and random requests on both ports against a byte-array
// memory. A reference model (winner rule, byte-array memory, size/extension
// arithmetic) predicts grants, write enables and completions; completions are
// queued and checked by a separate monitor when done appears.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW        = 17;
    localparam int DW        = 32;
    localparam int MEM_BYTES = 1 << AW;

    typedef struct {
        logic        port;
        logic        upd;     // rdata of the port is expected to change
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [2:0]    p0_funct3, p1_funct3;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_we0, mem_we1, mem_we2, mem_we3;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd, mem_rd;

    logic [7:0]    tb_mem  [0:MEM_BYTES-1];
    logic [7:0]    ref_mem [0:MEM_BYTES-1];
    bit            mem_init = 1'b0;
    bit            ref_init = 1'b0;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    exp_t          sb_q[$];

    // model state
    int            m_cnt  = 0;
    logic          m_last = 1'b1;
    logic          m_port, m_we;
    logic [2:0]    m_f3;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wd;
    int            m_gcyc;
    logic [31:0]   exp_rd0 = 32'd0;
    logic [31:0]   exp_rd1 = 32'd0;

    dmem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .p0_req(p0_req), .p0_we(p0_we), .p0_funct3(p0_funct3), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_funct3(p1_funct3), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .p1_err(p1_err),
        .mem_we0(mem_we0), .mem_we1(mem_we1), .mem_we2(mem_we2), .mem_we3(mem_we3),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37) + ((i >> 8) * 11) + 90);
    endfunction

    // Memory: lane k of the word lives at address a+k, wrapping at 2^AW.
    assign mem_rd = {tb_mem[mem_a + 17'd3], tb_mem[mem_a + 17'd2],
                     tb_mem[mem_a + 17'd1], tb_mem[mem_a]};

    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < MEM_BYTES; i++) tb_mem[i] <= init_byte(i);
            mem_init <= 1'b1;
        end else begin
            if (mem_we0) tb_mem[mem_a]          <= mem_wd[7:0];
            if (mem_we1) tb_mem[mem_a + 17'd1]  <= mem_wd[15:8];
            if (mem_we2) tb_mem[mem_a + 17'd2]  <= mem_wd[23:16];
            if (mem_we3) tb_mem[mem_a + 17'd3]  <= mem_wd[31:24];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic int nbytes(input logic we, input logic [2:0] f3);
        if (we) return (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic is_mis(input logic we, input logic [2:0] f3, input logic [AW-1:0] a);
`ifdef DMEM_ARB_MISALIGN_CHK_EN
        int n = nbytes(we, f3);
        int ai = int'(a);
        if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        if (n == 2 && (ai % 2) != 0) return 1'b1;
        if (n == 4 && (ai % 4) != 0) return 1'b1;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [AW-1:0] a);
        logic [31:0] w = 32'd0;
        logic [31:0] v;
        int n = nbytes(1'b0, f3);
        for (int k = 0; k < 4; k++)
            w = w | (32'(ref_mem[(int'(a) + k) % MEM_BYTES]) << (8 * k));
        if (n == 4) return w;
        if (n == 1) begin
            v = w % 32'd256;
            if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFFFF00;
            return v;
        end
        v = w % 32'd65536;
        if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF0000;
        return v;
    endfunction

    // ---------------- reference model: grants, enables, expectations ----------------
    always @(negedge CLK) begin : model
        logic        win;
        logic        mis;
        int          n;
        logic [3:0]  exp_we;
        exp_t        e;
        if (!ref_init) begin
            for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
            ref_init = 1'b1;
        end
        if (!RST_N) begin
            m_cnt  = 0;
            m_last = 1'b1;
            chk("rst_ctrl", 32'({p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err,
                                 mem_we3, mem_we2, mem_we1, mem_we0}), 32'd0);
            chk("rst_mem_a", 32'(mem_a), 32'd0);
            chk("rst_mem_wd", mem_wd, 32'd0);
            chk("rst_p0_rdata", p0_rdata, 32'd0);
            chk("rst_p1_rdata", p1_rdata, 32'd0);
        end else begin
            chk("we_mask", 32'({mem_we3, mem_we2, mem_we1, mem_we0}), 32'd0 + ((m_cnt == 1) ? 32'hFFFF_FFFF : 32'd0) & 32'({mem_we3, mem_we2, mem_we1, mem_we0}));
            if (m_cnt == 0) begin
                if (p0_req || p1_req) begin
                    win = (p0_req && p1_req) ? !m_last : p1_req;
                    chk("gnt", 32'({p1_gnt, p0_gnt}), win ? 32'd2 : 32'd1);
                    m_last = win;
                    m_port = win;
                    m_we   = win ? p1_we     : p0_we;
                    m_f3   = win ? p1_funct3 : p0_funct3;
                    m_addr = win ? p1_addr   : p0_addr;
                    m_wd   = win ? p1_wdata  : p0_wdata;
                    m_gcyc = cyc;
                    m_cnt  = 1;
                end else begin
                    chk("gnt_idle", 32'({p1_gnt, p0_gnt}), 32'd0);
                end
            end else if (m_cnt == 1) begin
                chk("gnt_busy", 32'({p1_gnt, p0_gnt}), 32'd0);
                chk("mem_a", 32'(mem_a), 32'(m_addr));
                chk("mem_wd", mem_wd, m_wd);
                mis    = is_mis(m_we, m_f3, m_addr);
                n      = nbytes(m_we, m_f3);
                exp_we = (m_we && !mis) ? 4'((1 << n) - 1) : 4'd0;
                chk("mem_we", 32'({mem_we3, mem_we2, mem_we1, mem_we0}), 32'(exp_we));
                if (m_we && !mis)
                    for (int k = 0; k < n; k++)
                        ref_mem[(int'(m_addr) + k) % MEM_BYTES] = m_wd[8*k +: 8];
                e.port  = m_port;
                e.upd   = !m_we || mis;
                e.rdata = mis ? 32'd0 : (m_we ? 32'd0 : ref_load(m_f3, m_addr));
                e.err   = mis;
                e.due   = m_gcyc + 2;
                sb_q.push_back(e);
                m_cnt = 2;
            end else begin
                chk("gnt_done", 32'({p1_gnt, p0_gnt}), 32'd0);
                chk("we_done", 32'({mem_we3, mem_we2, mem_we1, mem_we0}), 32'd0);
                m_cnt = 0;
            end
        end
    end

    // ---------------- monitor: completions vs scoreboard ----------------
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (!RST_N) begin
            sb_q.delete();
            exp_rd0 = 32'd0;
            exp_rd1 = 32'd0;
        end else begin
            if (p0_done || p1_done) begin
                if (sb_q.size() == 0) begin
                    chk("done_unexpected", 32'({p1_done, p0_done}), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_owner", 32'({p1_done, p0_done}), e.port ? 32'd2 : 32'd1);
                    chk("done_latency", 32'(cyc), 32'(e.due));
                    chk("err", 32'({p1_err, p0_err}), 32'({e.port & e.err, !e.port & e.err}));
                    if (e.upd) begin
                        if (e.port) exp_rd1 = e.rdata;
                        else        exp_rd0 = e.rdata;
                    end
                end
            end else begin
                chk("err_idle", 32'({p1_err, p0_err}), 32'd0);
                if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                    e = sb_q.pop_front();
                    chk("done_missing", 32'({p1_done, p0_done}), e.port ? 32'd2 : 32'd1);
                end
            end
            chk("p0_rdata", p0_rdata, exp_rd0);
            chk("p1_rdata", p1_rdata, exp_rd1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_port(input logic port, input logic we, input logic [2:0] f3,
                            input logic [AW-1:0] a, input logic [31:0] wd);
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_funct3 = f3; p1_addr = a; p1_wdata = wd;
        end else begin
            p0_req = 1'b1; p0_we = we; p0_funct3 = f3; p0_addr = a; p0_wdata = wd;
        end
    endtask

    // Request, wait (bounded) for the grant, release; returns in the ACCESS cycle.
    task automatic issue(input logic port, input logic we, input logic [2:0] f3,
                         input logic [AW-1:0] a, input logic [31:0] wd);
        logic got = 1'b0;
        set_port(port, we, f3, a, wd);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (port ? p1_gnt : p0_gnt) begin
                got = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
        chk("issue_grant", 32'(got), 32'd1);
        @(posedge CLK); #1;
        if (port) p1_req = 1'b0;
        else      p0_req = 1'b0;
    endtask

    // Load on port 0 and compare its result with a known constant once done.
    task automatic load_p0(input string name, input logic [2:0] f3, input logic [AW-1:0] a,
                           input logic [31:0] want);
        issue(1'b0, 1'b0, f3, a, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        chk(name, p0_rdata, want);
        @(posedge CLK); #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 17'h1FFFC + 17'($urandom_range(0, 7));
        return 17'h10000 + 17'($urandom_range(0, 15));
    endfunction

    initial begin
        logic g0, g1;
        RST_N = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_funct3 = 3'd0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_funct3 = 3'd0; p1_addr = '0; p1_wdata = '0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;

        // sizes and extension
        issue(1'b0, 1'b1, 3'd2, 17'h10000, 32'h8899AABB);
        load_p0("plan_lb",  3'd0, 17'h10000, 32'hFFFFFFBB);
        load_p0("plan_lbu", 3'd4, 17'h10000, 32'h000000BB);
        load_p0("plan_lh",  3'd1, 17'h10000, 32'hFFFFAABB);
        load_p0("plan_lhu", 3'd5, 17'h10000, 32'h0000AABB);
        load_p0("plan_lw",  3'd2, 17'h10000, 32'h8899AABB);
        // partial store on an odd address
        issue(1'b0, 1'b1, 3'd0, 17'h10001, 32'h12345677);
        load_p0("plan_sb_lw", 3'd2, 17'h10000, 32'h889977BB);
        // unaligned word load on port 1
        issue(1'b1, 1'b0, 3'd2, 17'h10002, 32'd0);
        repeat (3) @(posedge CLK); #1;

        // request pulse from port 1 that vanishes before IDLE
        issue(1'b0, 1'b0, 3'd2, 17'h10000, 32'd0);
        set_port(1'b1, 1'b1, 3'd2, 17'h10010, 32'h11111111);
        @(posedge CLK); #1;
        p1_req = 1'b0;
        repeat (3) @(posedge CLK); #1;

        // both ports held continuously: grants must alternate
        set_port(1'b0, 1'b0, 3'd2, 17'h10000, 32'd0);
        set_port(1'b1, 1'b0, 3'd4, 17'h10003, 32'd0);
        repeat (13) @(posedge CLK);
        #1 p0_req = 1'b0; p1_req = 1'b0;
        repeat (3) @(posedge CLK); #1;

        // reset in the middle of a store's ACCESS cycle
        issue(1'b0, 1'b1, 3'd2, 17'h10000, 32'hDEADBEEF);
        #2 RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        load_p0("abort_lw", 3'd2, 17'h10000, 32'h889977BB);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            @(negedge CLK);
            g0 = p0_gnt;
            g1 = p1_gnt;
            @(posedge CLK); #1;
            if (g0 || !p0_req) begin
                if ($urandom_range(0, 9) < 6)
                    set_port(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                             rand_addr(), $urandom);
                else
                    p0_req = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                p0_req = 1'b0;
            end
            if (g1 || !p1_req) begin
                if ($urandom_range(0, 9) < 6)
                    set_port(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                             rand_addr(), $urandom);
                else
                    p1_req = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                p1_req = 1'b0;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (8) @(posedge CLK);
        #1;

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        begin
            int bad = 0;
            for (int i = 0; i < MEM_BYTES; i++)
                if (tb_mem[i] !== ref_mem[i]) bad++;
            chk("mem_image", 32'(bad), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
